// File: rtl/ihp_bram_pkg.sv
// Shared constants, FSM encoding and the masked-merge helper for the
// 1024x16 dual-port SRAM responder model.
package ihp_bram_pkg;

    localparam int BRAM_ADDR_W = 10;
    localparam int BRAM_DATA_W = 16;
    localparam int BRAM_WORDS  = 1024;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } bram_state_t;

    // Bits with bm = 1 take new_word, all others keep old_word.
    function automatic logic [BRAM_DATA_W-1:0] masked_merge(
        input logic [BRAM_DATA_W-1:0] old_word,
        input logic [BRAM_DATA_W-1:0] new_word,
        input logic [BRAM_DATA_W-1:0] bm
    );
        return (old_word & ~bm) | (new_word & bm);
    endfunction

endpackage

// File: rtl/ihp_bram_port.sv
// One SRAM port: enable decode, masked write data and registered read data.
module ihp_bram_port
    import ihp_bram_pkg::*;
#(
    parameter int DATA_WIDTH = BRAM_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ready,
    input  logic                  men,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] bm,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] dout
);

    assign wr_en   = ready & men & wen;
    assign rd_en   = ready & men & ren;
    assign wr_data = masked_merge(rdata, din, bm);

    // rdata is the pre-write word, which gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
        end else if (rd_en) begin
            dout <= rdata;
        end
    end

endmodule

// File: rtl/ihp_bram_1024x16_model.sv
// Dual-port 1024x16 SRAM responder with post-reset clear, same-address
// collision flagging and sticky tie-pin checking.
//
//   state | meaning
//   CLEAR | zeroing mem[clr_cnt], ports ignored, DOUT held at 0
//   READY | normal dual-port access
module ihp_bram_1024x16_model
    import ihp_bram_pkg::*;
#(
    parameter int ADDR_WIDTH     = BRAM_ADDR_W,
    parameter int DATA_WIDTH     = BRAM_DATA_W,
    parameter int WORDS          = BRAM_WORDS,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  UserCLK,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] A_ADDR_BRAM,
    input  logic [DATA_WIDTH-1:0] A_DIN_BRAM,
    input  logic [DATA_WIDTH-1:0] A_BM_BRAM,
    input  logic                  A_WEN_BRAM,
    input  logic                  A_MEN_BRAM,
    input  logic                  A_REN_BRAM,
    input  logic                  A_TIE_HIGH_BRAM,
    input  logic                  A_TIE_LOW_BRAM,
    output logic [DATA_WIDTH-1:0] A_DOUT_BRAM,
    input  logic [ADDR_WIDTH-1:0] B_ADDR_BRAM,
    input  logic [DATA_WIDTH-1:0] B_DIN_BRAM,
    input  logic [DATA_WIDTH-1:0] B_BM_BRAM,
    input  logic                  B_WEN_BRAM,
    input  logic                  B_MEN_BRAM,
    input  logic                  B_REN_BRAM,
    input  logic                  B_TIE_HIGH_BRAM,
    input  logic                  B_TIE_LOW_BRAM,
    output logic [DATA_WIDTH-1:0] B_DOUT_BRAM,
    output logic                  init_done,
    output logic                  collision,
    output logic                  tie_error
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

    bram_state_t             state, state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [WORDS];
    logic [DATA_WIDTH-1:0]   a_rdata, b_rdata, a_wr_data, b_wr_data;
    logic                    a_wr_en, a_rd_en, b_wr_en, b_rd_en;
    logic                    ready, same_addr, coll_next, tie_bad;

    assign ready   = (state == READY);
    assign a_rdata = mem[A_ADDR_BRAM];
    assign b_rdata = mem[B_ADDR_BRAM];

    ihp_bram_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_a (
        .clk     (UserCLK),
        .reset   (reset),
        .ready   (ready),
        .men     (A_MEN_BRAM),
        .wen     (A_WEN_BRAM),
        .ren     (A_REN_BRAM),
        .din     (A_DIN_BRAM),
        .bm      (A_BM_BRAM),
        .rdata   (a_rdata),
        .wr_en   (a_wr_en),
        .rd_en   (a_rd_en),
        .wr_data (a_wr_data),
        .dout    (A_DOUT_BRAM)
    );

    ihp_bram_port #(.DATA_WIDTH(DATA_WIDTH)) u_port_b (
        .clk     (UserCLK),
        .reset   (reset),
        .ready   (ready),
        .men     (B_MEN_BRAM),
        .wen     (B_WEN_BRAM),
        .ren     (B_REN_BRAM),
        .din     (B_DIN_BRAM),
        .bm      (B_BM_BRAM),
        .rdata   (b_rdata),
        .wr_en   (b_wr_en),
        .rd_en   (b_rd_en),
        .wr_data (b_wr_data),
        .dout    (B_DOUT_BRAM)
    );

    always_ff @(posedge UserCLK) begin
        if (reset) begin
            state   <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_cnt == LAST_ADDR) state_next = READY;
            READY:   state_next = READY;
            default: state_next = READY;
        endcase
    end

    // Both ports writing one word: B merges first, A on top so A wins overlaps.
    always_ff @(posedge UserCLK) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (a_wr_en && b_wr_en && same_addr) begin
                mem[A_ADDR_BRAM] <= masked_merge(b_wr_data, A_DIN_BRAM, A_BM_BRAM);
            end else begin
                if (a_wr_en) mem[A_ADDR_BRAM] <= a_wr_data;
                if (b_wr_en) mem[B_ADDR_BRAM] <= b_wr_data;
            end
        end
    end

    assign same_addr = (A_ADDR_BRAM == B_ADDR_BRAM);
    assign coll_next = same_addr &&
                       ((a_wr_en && b_wr_en && ((A_BM_BRAM & B_BM_BRAM) != '0)) ||
                        (a_wr_en && b_rd_en && !b_wr_en) ||
                        (b_wr_en && a_rd_en && !a_wr_en));
    assign tie_bad   = !A_TIE_HIGH_BRAM || A_TIE_LOW_BRAM ||
                       !B_TIE_HIGH_BRAM || B_TIE_LOW_BRAM;

    always_ff @(posedge UserCLK) begin
        if (reset) begin
            init_done <= 1'b0;
            collision <= 1'b0;
            tie_error <= 1'b0;
        end else begin
            init_done <= (state_next == READY);
            collision <= coll_next;
            if (tie_bad) tie_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ihp_bram_1024x16_model.sv
// Directed plus randomized bench for the 1024x16 dual-port SRAM model,
// checked against a word-array reference that applies port writes in order.
module tb_ihp_bram_1024x16_model;

    logic        clk;
    logic        reset;
    logic [9:0]  a_addr, b_addr;
    logic [15:0] a_din, a_bm, b_din, b_bm;
    logic        a_wen, a_men, a_ren, a_th, a_tl;
    logic        b_wen, b_men, b_ren, b_th, b_tl;
    logic [15:0] a_dout, b_dout;
    logic        init_done, collision, tie_error;

    int          vectors;
    int          miscompares;
    int          n;

    logic [15:0] ref_mem [1024];
    logic [15:0] exp_a, exp_b;
    logic        exp_coll, exp_tie;

    ihp_bram_1024x16_model dut (
        .UserCLK         (clk),
        .reset           (reset),
        .A_ADDR_BRAM     (a_addr),
        .A_DIN_BRAM      (a_din),
        .A_BM_BRAM       (a_bm),
        .A_WEN_BRAM      (a_wen),
        .A_MEN_BRAM      (a_men),
        .A_REN_BRAM      (a_ren),
        .A_TIE_HIGH_BRAM (a_th),
        .A_TIE_LOW_BRAM  (a_tl),
        .A_DOUT_BRAM     (a_dout),
        .B_ADDR_BRAM     (b_addr),
        .B_DIN_BRAM      (b_din),
        .B_BM_BRAM       (b_bm),
        .B_WEN_BRAM      (b_wen),
        .B_MEN_BRAM      (b_men),
        .B_REN_BRAM      (b_ren),
        .B_TIE_HIGH_BRAM (b_th),
        .B_TIE_LOW_BRAM  (b_tl),
        .B_DOUT_BRAM     (b_dout),
        .init_done       (init_done),
        .collision       (collision),
        .tie_error       (tie_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic men, input logic wen, input logic ren,
                         input logic [9:0] addr, input logic [15:0] din, input logic [15:0] bm);
        a_men = men; a_wen = wen; a_ren = ren; a_addr = addr; a_din = din; a_bm = bm;
    endtask

    task automatic set_b(input logic men, input logic wen, input logic ren,
                         input logic [9:0] addr, input logic [15:0] din, input logic [15:0] bm);
        b_men = men; b_wen = wen; b_ren = ren; b_addr = addr; b_din = din; b_bm = bm;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 16'h0000);
        set_b(1'b0, 1'b0, 1'b0, 10'h000, 16'h0000, 16'h0000);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0000;
        exp_a = 16'h0000; exp_b = 16'h0000; exp_coll = 1'b0; exp_tie = 1'b0;
    endtask

    // One clock in READY: predict from the current inputs, clock, compare all outputs.
    task automatic step();
        logic        a_wr, b_wr, a_rd, b_rd, same;
        logic [15:0] old_a, old_b;
        a_wr  = a_men && a_wen;
        b_wr  = b_men && b_wen;
        a_rd  = a_men && a_ren;
        b_rd  = b_men && b_ren;
        same  = a_men && b_men && (a_addr == b_addr);
        old_a = ref_mem[a_addr];
        old_b = ref_mem[b_addr];
        exp_coll = same && ((a_wr && b_wr && ((a_bm & b_bm) != 16'h0)) ||
                            (a_wr && b_rd && !b_wr) || (b_wr && a_rd && !a_wr));
        if (a_rd) exp_a = old_a;
        if (b_rd) exp_b = old_b;
        if (b_wr) ref_mem[b_addr] = (old_b & ~b_bm) | (b_din & b_bm);
        if (a_wr) ref_mem[a_addr] = (ref_mem[a_addr] & ~a_bm) | (a_din & a_bm);
        if (!a_th || a_tl || !b_th || b_tl) exp_tie = 1'b1;
        tick();
        check("a_dout", a_dout, exp_a);
        check("b_dout", b_dout, exp_b);
        check("collision", {15'h0, collision}, {15'h0, exp_coll});
        check("tie_error", {15'h0, tie_error}, {15'h0, exp_tie});
        check("init_done", {15'h0, init_done}, 16'h0001);
    endtask

    task automatic count_clear(output int cycles);
        cycles = 0;
        while (!init_done && cycles < 1100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        a_th = 1'b1; a_tl = 1'b0; b_th = 1'b1; b_tl = 1'b0;
        idle();
        model_reset();
        tick(); tick(); tick();
        check("rst_a_dout", a_dout, 16'h0000);
        check("rst_b_dout", b_dout, 16'h0000);
        check("rst_init_done", {15'h0, init_done}, 16'h0000);
        check("rst_collision", {15'h0, collision}, 16'h0000);
        check("rst_tie_error", {15'h0, tie_error}, 16'h0000);

        // Port activity during clear must be ignored.
        set_a(1'b1, 1'b1, 1'b1, 10'h000, 16'hFFFF, 16'hFFFF);
        reset = 1'b0;
        count_clear(n);
        check("clear_cycles", 16'(n), 16'd1024);
        check("clear_a_dout", a_dout, 16'h0000);
        idle();

        set_a(1'b1, 1'b0, 1'b1, 10'h3FF, 16'h0000, 16'h0000);
        step();
        check("read_3ff", a_dout, 16'h0000);
        set_a(1'b1, 1'b0, 1'b1, 10'h000, 16'h0000, 16'h0000);
        step();
        check("read_0_after_clear", a_dout, 16'h0000);

        set_a(1'b1, 1'b1, 1'b0, 10'h005, 16'hBEEF, 16'hFFFF);
        step();
        set_a(1'b1, 1'b1, 1'b0, 10'h005, 16'h1234, 16'h00FF);
        step();
        set_a(1'b1, 1'b0, 1'b1, 10'h005, 16'h0000, 16'h0000);
        step();
        check("masked_write", a_dout, 16'hBE34);
        set_a(1'b1, 1'b1, 1'b1, 10'h005, 16'h0000, 16'hFFFF);
        step();
        check("read_first", a_dout, 16'hBE34);
        idle();
        step();
        check("dout_hold", a_dout, 16'hBE34);

        set_b(1'b1, 1'b1, 1'b0, 10'h010, 16'h5555, 16'hFFFF);
        step();
        set_a(1'b1, 1'b1, 1'b0, 10'h010, 16'hAAAA, 16'hFFFF);
        set_b(1'b1, 1'b0, 1'b1, 10'h010, 16'h0000, 16'h0000);
        step();
        check("wr_rd_old_word", b_dout, 16'h5555);
        check("wr_rd_collision", {15'h0, collision}, 16'h0001);
        idle();
        step();
        check("collision_pulse_end", {15'h0, collision}, 16'h0000);
        set_a(1'b1, 1'b0, 1'b1, 10'h010, 16'h0000, 16'h0000);
        step();
        check("wr_rd_new_word", a_dout, 16'hAAAA);

        set_a(1'b1, 1'b1, 1'b0, 10'h020, 16'h00FF, 16'h0FF0);
        set_b(1'b1, 1'b1, 1'b0, 10'h020, 16'hFF00, 16'hFF00);
        step();
        check("ww_collision", {15'h0, collision}, 16'h0001);
        idle();
        set_a(1'b1, 1'b0, 1'b1, 10'h020, 16'h0000, 16'h0000);
        set_b(1'b1, 1'b0, 1'b1, 10'h020, 16'h0000, 16'h0000);
        step();
        check("ww_merge", a_dout, 16'hF0F0);
        check("rr_no_collision", {15'h0, collision}, 16'h0000);

        for (int i = 0; i < 300; i++) begin
            set_a(1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7)),
                  16'($urandom), 16'($urandom));
            set_b(1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7)),
                  16'($urandom), 16'($urandom));
            step();
        end
        idle();

        a_tl = 1'b1;
        step();
        a_tl = 1'b0;
        check("tie_set", {15'h0, tie_error}, 16'h0001);
        step();
        step();
        check("tie_sticky", {15'h0, tie_error}, 16'h0001);

        // Reset partway through the clear restarts it from address 0.
        reset = 1'b1;
        tick(); tick();
        check("rst2_tie_error", {15'h0, tie_error}, 16'h0000);
        check("rst2_init_done", {15'h0, init_done}, 16'h0000);
        check("rst2_a_dout", a_dout, 16'h0000);
        reset = 1'b0;
        for (int i = 0; i < 500; i++) tick();
        check("mid_clear_init_done", {15'h0, init_done}, 16'h0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_clear(n);
        check("reclear_cycles", 16'(n), 16'd1024);
        model_reset();
        set_a(1'b1, 1'b0, 1'b1, 10'h020, 16'h0000, 16'h0000);
        set_b(1'b1, 1'b0, 1'b1, 10'h005, 16'h0000, 16'h0000);
        step();
        check("reclear_word", a_dout, 16'h0000);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
